mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
// - Sits directly downstream of the L1 instruction and data caches; merges their line-fill requests onto the single memory bus.
// - Grants one client at a time, forwards request to bus, routes the 8-beat response burst back to the granted client only.
// - Client 0 = I-cache, client 1 = D-cache; each side uses the reqcyc/reqack/respcyc/respack protocol used by the caches.
// PARAMETERS
// - ADDR_W  64  request address width
// - DATA_W  64  response beat width
// - TAG_W   13  request/response tag width; bit 12 = READ
// - BEATS   8   response beats per read transaction (one cache line)
// PORTS
// - clk              in   1       clock; all logic on posedge
// - reset            in   1       synchronous, active-low reset
// - c_reqcyc[1:0]    in   2       client request valid (index = client)
// - c_req[1:0]       in   ADDR_W  client request address, per client
// - c_reqtag[1:0]    in   TAG_W   client request tag, per client
// - c_reqack[1:0]    out  2       one-cycle pulse: request accepted
// - c_respcyc[1:0]   out  2       response beat valid to client
// - c_resp           out  DATA_W  response data (shared, valid with c_respcyc)
// - c_resptag        out  TAG_W   response tag (shared)
// - c_respack[1:0]   in   2       client accepts beat
// - bus_reqcyc       out  1       memory request valid
// - bus_req          out  ADDR_W  memory request address
// - bus_reqtag       out  TAG_W   memory request tag
// - bus_reqack       in   1       memory accepted request
// - bus_respcyc      in   1       memory response beat valid
// - bus_resp         in   DATA_W  memory response data
// - bus_resptag      in   TAG_W   memory response tag
// - bus_respack      out  1       beat accepted, forwarded from granted client
// BEHAVIOUR
// - Reset (reset==0 at posedge): state=IDLE, grant=0, last_grant=1, beat_cnt=0; all outputs 0 (bus_req/bus_reqtag 0).
// - FSM: IDLE -> ISSUE -> RESP -> IDLE. Write transactions (tag[12]==0): ISSUE -> IDLE.
// - IDLE: if any c_reqcyc, pick winner (round-robin: client != last_grant wins on tie; sole requester always wins).
//   Same edge: latch c_req/c_reqtag into bus_req/bus_reqtag, set bus_reqcyc=1, pulse c_reqack[winner]=1 for exactly 1 cycle,
//   grant=winner, last_grant=winner, go ISSUE. Grant latency: 1 cycle from c_reqcyc to c_reqack.
// - ISSUE: hold bus_reqcyc/bus_req/bus_reqtag stable until bus_reqack==1; on that edge clear bus_reqcyc;
//   read -> RESP with beat_cnt=0; write -> IDLE.
// - RESP (combinational routing): c_respcyc[grant]=bus_respcyc; c_respcyc[!grant]=0; c_resp=bus_resp;
//   c_resptag=bus_resptag; bus_respack=c_respack[grant]. Non-granted c_respack ignored.
// - Beat accepted when bus_respcyc && bus_respack in same cycle; beat_cnt increments (3 bits for BEATS=8).
//   Accepting beat BEATS-1 -> IDLE next cycle, beat_cnt=0. New grant earliest the cycle after.
// - Outside RESP: c_respcyc=0, bus_respack=0; bus_respcyc outside RESP ignored (no state change).
// - Requests arriving during ISSUE/RESP stay pending (client holds c_reqcyc); no queueing inside arbiter.
// - c_reqcyc dropped by client after grant: transaction still completes.
// - Reset mid-ISSUE/RESP: transaction abandoned, everything returns to reset values next cycle.
// - Only one outstanding memory transaction at any time.
// CONFIGURATION
// - Macro ARB_FIXED_PRIO_EN:
//   defined -> fixed priority, D-cache (client 1) always wins when both request; last_grant unused.
//   undefined -> round-robin as above (default).
// TESTING
// - I-cache alone: c_reqcyc[0]=1, req=0x1000, tag[12]=1 -> c_reqack[0] pulse 1 cycle; bus_req=0x1000 until bus_reqack; 8 beats on c_respcyc[0], none on [1].
// - Both request same cycle after reset (last_grant=1): client 0 granted first, then client 1 after 8th beat accepted; bus_req order 0x1000, 0x2040.
// - Back-to-back from both with ARB_FIXED_PRIO_EN: client 1 granted every time both request; client 0 only when c_reqcyc[1]=0.
// - Stalled bus: bus_reqack held 0 for 20 cycles -> bus_reqcyc/bus_req stable all 20 cycles; no c_respcyc.
// - Response backpressure: c_respack[grant]=0 on beat 3 -> bus_respack=0, beat_cnt holds at 3; FSM stays RESP until 8 accepted beats.
// - Reset asserted after beat 4 of a read: next cycle all outputs 0, state IDLE; subsequent request completes normally with 8 beats.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Port bundle for mem_arbiter: two cache clients (index 0 = I-cache, 1 = D-cache) and the shared memory bus.
// Requests: the requester holds reqcyc and the address and tag steady until it sees a one-cycle reqack pulse.
// Response beats: a beat transfers on a posedge where respcyc and respack are both 1.
interface mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 13
);
  logic [1:0]             c_reqcyc;
  logic [1:0][ADDR_W-1:0] c_req;
  logic [1:0][TAG_W-1:0]  c_reqtag;
  logic [1:0]             c_reqack;
  logic [1:0]             c_respcyc;
  logic [DATA_W-1:0]      c_resp;
  logic [TAG_W-1:0]       c_resptag;
  logic [1:0]             c_respack;

  logic                   bus_reqcyc;
  logic [ADDR_W-1:0]      bus_req;
  logic [TAG_W-1:0]       bus_reqtag;
  logic                   bus_reqack;
  logic                   bus_respcyc;
  logic [DATA_W-1:0]      bus_resp;
  logic [TAG_W-1:0]       bus_resptag;
  logic                   bus_respack;

  modport slave (
    input  c_reqcyc, c_req, c_reqtag, c_respack,
           bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    output c_reqack, c_respcyc, c_resp, c_resptag,
           bus_reqcyc, bus_req, bus_reqtag, bus_respack
  );

  modport master (
    output c_reqcyc, c_req, c_reqtag, c_respack,
           bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    input  c_reqack, c_respcyc, c_resp, c_resptag,
           bus_reqcyc, bus_req, bus_reqtag, bus_respack
  );
endinterface

// File: rtl/mem_arbiter.sv
// Merges I-cache and D-cache line-fill requests onto one memory bus, one transaction at a time.
// Define ARB_FIXED_PRIO_EN for fixed priority (D-cache wins ties); default is round-robin.
module mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 13,
  parameter int BEATS  = 8
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus_if,
  output logic [1:0]    dbg_state
);
  localparam int CNT_W    = $clog2(BEATS);
  localparam int READ_BIT = TAG_W - 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              bus_reqcyc_q, bus_reqcyc_d;
  logic [ADDR_W-1:0] bus_req_q, bus_req_d;
  logic [TAG_W-1:0]  bus_reqtag_q, bus_reqtag_d;
  logic [1:0]        c_reqack_q, c_reqack_d;

  logic              winner;
  logic              in_resp;
  logic              beat_acc;

  always_comb begin
`ifdef ARB_FIXED_PRIO_EN
    winner = bus_if.c_reqcyc[1];
`else
    // On a tie the client that was not served last goes next.
    if (&bus_if.c_reqcyc) winner = ~last_grant_q;
    else                  winner = bus_if.c_reqcyc[1];
`endif
  end

  assign in_resp  = (state_q == ST_RESP);
  assign beat_acc = in_resp && bus_if.bus_respcyc && bus_if.c_respack[grant_q];

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    bus_reqcyc_d = bus_reqcyc_q;
    bus_req_d    = bus_req_q;
    bus_reqtag_d = bus_reqtag_q;
    c_reqack_d   = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (|bus_if.c_reqcyc) begin
          grant_d      = winner;
          last_grant_d = winner;
          bus_req_d    = bus_if.c_req[winner];
          bus_reqtag_d = bus_if.c_reqtag[winner];
          bus_reqcyc_d = 1'b1;
          c_reqack_d   = winner ? 2'b10 : 2'b01;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus_if.bus_reqack) begin
          bus_reqcyc_d = 1'b0;
          beat_cnt_d   = '0;
          state_d      = bus_reqtag_q[READ_BIT] ? ST_RESP : ST_IDLE;
        end
      end
      ST_RESP: begin
        if (beat_acc) begin
          if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
            beat_cnt_d = '0;
            state_d    = ST_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= '0;
      bus_reqcyc_q <= 1'b0;
      bus_req_q    <= '0;
      bus_reqtag_q <= '0;
      c_reqack_q   <= 2'b00;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      bus_reqcyc_q <= bus_reqcyc_d;
      bus_req_q    <= bus_req_d;
      bus_reqtag_q <= bus_reqtag_d;
      c_reqack_q   <= c_reqack_d;
    end
  end

  // Response path is purely combinational and only open while a read is in flight.
  always_comb begin
    bus_if.c_respcyc   = 2'b00;
    bus_if.c_resp      = '0;
    bus_if.c_resptag   = '0;
    bus_if.bus_respack = 1'b0;
    if (in_resp) begin
      bus_if.c_respcyc[grant_q] = bus_if.bus_respcyc;
      bus_if.c_resp             = bus_if.bus_resp;
      bus_if.c_resptag          = bus_if.bus_resptag;
      bus_if.bus_respack        = bus_if.c_respack[grant_q];
    end
  end

  assign bus_if.c_reqack   = c_reqack_q;
  assign bus_if.bus_reqcyc = bus_reqcyc_q;
  assign bus_if.bus_req    = bus_req_q;
  assign bus_if.bus_reqtag = bus_reqtag_q;
  assign dbg_state         = state_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: client driver tasks, a reactive memory model and a scoreboard of expected requests/beats.
module tb_mem_arbiter;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int TAG_W  = 13;
  localparam int BEATS  = 8;
  localparam int RW     = TAG_W + ADDR_W;
  localparam int EW     = 1 + TAG_W + DATA_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [RW-1:0] exp_req_q[$];
  logic [EW-1:0] exp_beat_q[$];
  logic [EW-1:0] e;

  int                m_state = 0;
  int                m_cnt = 0;
  int                m_beat = 0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [TAG_W-1:0]  m_tag = '0;
  bit                m_kill = 1'b0;
  int                stall_cycles = 0;
  bit                beat_acc_s = 1'b0;
  int                beats_seen = 0;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) arb_if ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .BEATS(BEATS)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus_if    (arb_if.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #4;
  endtask

  task automatic exp_read(input logic k, input logic [ADDR_W-1:0] addr, input logic [TAG_W-1:0] tag);
    exp_req_q.push_back({tag, addr});
    for (int i = 0; i < BEATS; i++) exp_beat_q.push_back({k, tag, addr + 64'(i)});
  endtask

  task automatic exp_write(input logic [ADDR_W-1:0] addr, input logic [TAG_W-1:0] tag);
    exp_req_q.push_back({tag, addr});
  endtask

  task automatic client_req(input int k, input logic [ADDR_W-1:0] addr, input logic [TAG_W-1:0] tag,
                            output int lat);
    @(negedge clk);
    arb_if.c_reqcyc[k] = 1'b1;
    arb_if.c_req[k]    = addr;
    arb_if.c_reqtag[k] = tag;
    lat = 0;
    #4;
    while (!arb_if.c_reqack[k] && lat < 500) begin
      @(negedge clk);
      #4;
      lat++;
    end
    if (!arb_if.c_reqack[k]) check($sformatf("ack_timeout%0d", k), arb_if.c_reqack[k], 1);
    @(negedge clk);
    arb_if.c_reqcyc[k] = 1'b0;
    #4;
    check($sformatf("ack_pulse%0d", k), arb_if.c_reqack[k], 0);
  endtask

  task automatic wait_done(input bit jitter);
    int n;
    n = 0;
    while ((exp_req_q.size() != 0 || exp_beat_q.size() != 0 || m_state != 0 || dbg_state != S_IDLE)
           && n < 3000) begin
      @(negedge clk);
      if (jitter) arb_if.c_respack = 2'($urandom_range(0, 3));
      #4;
      n++;
    end
    arb_if.c_respack = 2'b11;
    check("drain", exp_req_q.size() + exp_beat_q.size(), 0);
    check("idle_after", dbg_state, S_IDLE);
  endtask

  task automatic do_reset();
    m_kill = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    arb_if.c_reqcyc  = 2'b00;
    arb_if.c_respack = 2'b11;
    @(negedge clk);
    reset = 1'b1;
    exp_req_q.delete();
    exp_beat_q.delete();
  endtask

  // Memory model: acks a request after stall_cycles, then streams BEATS beats with data = addr + beat.
  initial begin
    arb_if.bus_reqack  = 1'b0;
    arb_if.bus_respcyc = 1'b0;
    arb_if.bus_resp    = '0;
    arb_if.bus_resptag = '0;
    forever begin
      @(negedge clk);
      if (m_kill) begin
        m_kill = 1'b0;
        m_state = 0;
        arb_if.bus_reqack  = 1'b0;
        arb_if.bus_respcyc = 1'b0;
      end else begin
        case (m_state)
          0: if (arb_if.bus_reqcyc) begin
            m_addr  = arb_if.bus_req;
            m_tag   = arb_if.bus_reqtag;
            m_cnt   = stall_cycles;
            m_state = 1;
          end
          1: if (m_cnt == 0) begin
            arb_if.bus_reqack = 1'b1;
            m_state = 2;
          end else m_cnt--;
          2: begin
            arb_if.bus_reqack = 1'b0;
            if (m_tag[TAG_W-1]) begin
              m_beat = 0;
              arb_if.bus_respcyc = 1'b1;
              arb_if.bus_resp    = m_addr;
              arb_if.bus_resptag = m_tag;
              m_state = 3;
            end else m_state = 0;
          end
          default: if (beat_acc_s) begin
            m_beat++;
            if (m_beat == BEATS) begin
              arb_if.bus_respcyc = 1'b0;
              m_state = 0;
            end else arb_if.bus_resp = m_addr + 64'(m_beat);
          end
        endcase
      end
    end
  end

  // Scoreboard: pops one expected request per bus handshake and one expected beat per accepted beat.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      beat_acc_s = arb_if.bus_respcyc && arb_if.bus_respack;
      if (reset && arb_if.bus_reqcyc && arb_if.bus_reqack) begin
        if (exp_req_q.size() == 0) check("req_queue", exp_req_q.size(), 1);
        else check("bus_req", {arb_if.bus_reqtag, arb_if.bus_req}, exp_req_q.pop_front());
      end
      if (reset && beat_acc_s) begin
        if (exp_beat_q.size() == 0) check("beat_queue", exp_beat_q.size(), 1);
        else begin
          e = exp_beat_q.pop_front();
          check("beat_route", arb_if.c_respcyc, e[EW-1] ? 2'b10 : 2'b01);
          check("beat_data", {arb_if.c_resptag, arb_if.c_resp}, e[EW-2:0]);
        end
        beats_seen++;
      end
    end
  end

  initial begin
    int lat0, lat1;
    logic [ADDR_W-1:0] ra;
    logic [TAG_W-1:0]  rt;
    int rk;
    arb_if.c_reqcyc  = 2'b00;
    arb_if.c_req     = '0;
    arb_if.c_reqtag  = '0;
    arb_if.c_respack = 2'b11;

    do_reset();
    #4;
    check("rst_state", dbg_state, S_IDLE);
    check("rst_bus_reqcyc", arb_if.bus_reqcyc, 0);
    check("rst_bus_req", {arb_if.bus_reqtag, arb_if.bus_req}, 0);
    check("rst_reqack", arb_if.c_reqack, 0);
    check("rst_respcyc", arb_if.c_respcyc, 0);
    check("rst_respack", arb_if.bus_respack, 0);

    // I-cache alone
    stall_cycles = 2;
    exp_read(1'b0, 64'h1000, 13'h1005);
    client_req(0, 64'h1000, 13'h1005, lat0);
    check("grant_latency", lat0, 1);
    wait_done(1'b0);

    // Both request together right after reset
    do_reset();
    stall_cycles = 1;
`ifdef ARB_FIXED_PRIO_EN
    exp_read(1'b1, 64'h2040, 13'h1022);
    exp_read(1'b0, 64'h1000, 13'h1011);
`else
    exp_read(1'b0, 64'h1000, 13'h1011);
    exp_read(1'b1, 64'h2040, 13'h1022);
`endif
    fork
      client_req(0, 64'h1000, 13'h1011, lat0);
      client_req(1, 64'h2040, 13'h1022, lat1);
    join
    wait_done(1'b0);

    // Client 0 served last, so a tie goes to client 1 in both arbitration modes
    exp_read(1'b0, 64'h3000, 13'h1100);
    client_req(0, 64'h3000, 13'h1100, lat0);
    wait_done(1'b0);
    exp_read(1'b1, 64'h3040, 13'h1201);
    exp_read(1'b0, 64'h3080, 13'h1302);
    fork
      client_req(0, 64'h3080, 13'h1302, lat0);
      client_req(1, 64'h3040, 13'h1201, lat1);
    join
    wait_done(1'b0);

    // Write: no response phase
    stall_cycles = 0;
    exp_write(64'h4000, 13'h0033);
    client_req(1, 64'h4000, 13'h0033, lat1);
    check("write_latency", lat1, 1);
    wait_done(1'b0);

    // Stalled bus
    stall_cycles = 20;
    exp_read(1'b0, 64'h5000, 13'h1044);
    client_req(0, 64'h5000, 13'h1044, lat0);
    check("stall_state", dbg_state, S_ISSUE);
    for (int n = 0; n < 20; n++) begin
      tick();
      check("stall_reqcyc", arb_if.bus_reqcyc, 1);
      check("stall_req", {arb_if.bus_reqtag, arb_if.bus_req}, {13'h1044, 64'h5000});
      check("stall_respcyc", arb_if.c_respcyc, 0);
    end
    wait_done(1'b0);

    // Backpressure from the granted client on beat 3
    stall_cycles = 0;
    beats_seen = 0;
    exp_read(1'b1, 64'h6000, 13'h1055);
    client_req(1, 64'h6000, 13'h1055, lat1);
    for (int n = 0; n < 200 && beats_seen < 3; n++) tick();
    @(negedge clk);
    arb_if.c_respack[1] = 1'b0;
    for (int n = 0; n < 4; n++) begin
      #4;
      check("bp_respack", arb_if.bus_respack, 0);
      check("bp_respcyc", arb_if.c_respcyc, 2'b10);
      check("bp_state", dbg_state, S_RESP);
      check("bp_beats", beats_seen, 3);
      @(negedge clk);
    end
    arb_if.c_respack[1] = 1'b1;
    wait_done(1'b0);

    // Reset after beat 4 of a read, then a clean read
    stall_cycles = 1;
    beats_seen = 0;
    exp_read(1'b0, 64'h7000, 13'h1066);
    client_req(0, 64'h7000, 13'h1066, lat0);
    for (int n = 0; n < 200 && beats_seen < 4; n++) tick();
    do_reset();
    #4;
    check("mid_rst_state", dbg_state, S_IDLE);
    check("mid_rst_reqcyc", arb_if.bus_reqcyc, 0);
    check("mid_rst_req", {arb_if.bus_reqtag, arb_if.bus_req}, 0);
    check("mid_rst_respcyc", arb_if.c_respcyc, 0);
    check("mid_rst_resp", {arb_if.c_resptag, arb_if.c_resp}, 0);
    check("mid_rst_respack", arb_if.bus_respack, 0);
    beats_seen = 0;
    exp_read(1'b0, 64'h7100, 13'h1077);
    client_req(0, 64'h7100, 13'h1077, lat0);
    wait_done(1'b0);
    check("post_rst_beats", beats_seen, BEATS);

    // Random single-client traffic with response backpressure jitter
    for (int i = 0; i < 8; i++) begin
      rk = $urandom_range(0, 1);
      ra = 64'($urandom_range(0, 16'hffff)) << 6;
      rt = {1'($urandom_range(0, 1)), 12'($urandom_range(0, 12'hfff))};
      stall_cycles = $urandom_range(0, 3);
      if (rt[TAG_W-1]) exp_read(rk[0], ra, rt);
      else exp_write(ra, rt);
      client_req(rk, ra, rt, lat0);
      wait_done(1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
